// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: state encoding, signature constants and folding helpers for gate_sweep
package gate_sweep_pkg;
   localparam int SIG_W = 16;
   localparam logic [SIG_W-1:0] SIG_SEED = 16'hFFFF;
   // Widest packed gate result is 5*8 = 40 bits, rounded up to three 16-bit chunks
   localparam int P_MAX = 48;
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic logic [SIG_W-1:0] fold16(input logic [P_MAX-1:0] p);
      fold16 = p[15:0] ^ p[31:16] ^ p[47:32];
   endfunction

   function automatic logic [SIG_W-1:0] rotl1(input logic [SIG_W-1:0] s);
      rotl1 = {s[SIG_W-2:0], s[SIG_W-1]};
   endfunction
endpackage

// File: rtl/gate_sweep_bitwise_gates.sv
// bitwise_gates: combinational WIDTH-wide Not/Nand/And/Or/Xor of two operands
module bitwise_gates #(
   parameter int WIDTH = 1
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_not,
   output logic [WIDTH-1:0] o_nand,
   output logic [WIDTH-1:0] o_and,
   output logic [WIDTH-1:0] o_or,
   output logic [WIDTH-1:0] o_xor
);
   assign o_not  = ~i_a;
   assign o_nand = ~(i_a & i_b);
   assign o_and  = i_a & i_b;
   assign o_or   = i_a | i_b;
   assign o_xor  = i_a ^ i_b;
endmodule

// File: rtl/gate_sweep.sv
// gate_sweep: start/done-handshaked exhaustive exerciser for the bitwise gate set with a 16-bit signature
module gate_sweep
   import gate_sweep_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int HOLD  = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   a_not,
   output logic [WIDTH-1:0]   ab_nand,
   output logic [WIDTH-1:0]   ab_and,
   output logic [WIDTH-1:0]   ab_or,
   output logic [WIDTH-1:0]   ab_xor,
   output logic               out_valid,
   output logic               busy,
   output logic               done,
   output logic [SIG_W-1:0]   signature,
   output logic [2*WIDTH:0]   vec_count
);
   localparam int VW = 2 * WIDTH;

   logic [1:0]       r_state;
   logic [VW-1:0]    r_vec;
   logic [7:0]       r_hold;
   logic             r_valid;
   logic [SIG_W-1:0] r_sig;
   logic [VW:0]      r_cnt;
   logic [WIDTH-1:0] r_not, r_nand, r_and, r_or, r_xor;
   logic [WIDTH-1:0] w_not, w_nand, w_and, w_or, w_xor;
   logic [P_MAX-1:0] w_p;
   logic             w_busy, w_go, w_abort, w_hold_end, w_last;

   bitwise_gates #(.WIDTH(WIDTH)) u_gates (
      .i_a    (a),
      .i_b    (b),
      .o_not  (w_not),
      .o_nand (w_nand),
      .o_and  (w_and),
      .o_or   (w_or),
      .o_xor  (w_xor)
   );

   // a is the low half of the vector counter so it toggles fastest
   assign {b, a}     = r_vec;
   assign a_not      = r_not;
   assign ab_nand    = r_nand;
   assign ab_and     = r_and;
   assign ab_or      = r_or;
   assign ab_xor     = r_xor;
   assign out_valid  = r_valid;
   assign signature  = r_sig;
   assign vec_count  = r_cnt;
   assign busy       = w_busy;
   assign done       = (r_state == S_DONE);
   assign w_busy     = (r_state == S_RUN) || (r_state == S_DRAIN);
   assign w_go       = start && !w_busy;
   assign w_abort    = abort && w_busy;
   assign w_hold_end = (r_hold == 8'(HOLD - 1));
   assign w_last     = &r_vec;
   assign w_p        = P_MAX'({r_xor, r_or, r_and, r_nand, r_not});

   // Gate results track the operands continuously with one cycle of latency
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_not  <= '0;
         r_nand <= '0;
         r_and  <= '0;
         r_or   <= '0;
         r_xor  <= '0;
      end else begin
         r_not  <= w_not;
         r_nand <= w_nand;
         r_and  <= w_and;
         r_or   <= w_or;
         r_xor  <= w_xor;
      end
   end

   // Sweep FSM: steps the vector counter, flags each vector's first registered result and folds it into the signature
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_vec   <= '0;
         r_hold  <= '0;
         r_valid <= 1'b0;
         r_sig   <= '0;
         r_cnt   <= '0;
      end else begin
         r_valid <= (r_state == S_RUN) && (r_hold == '0) && !abort;
         if (w_go) begin
            r_state <= S_RUN;
            r_vec   <= '0;
            r_hold  <= '0;
            r_sig   <= SIG_SEED;
            r_cnt   <= '0;
         end else if (w_abort) begin
            r_state <= S_IDLE;
         end else begin
            if (r_valid) begin
               r_sig <= rotl1(r_sig) ^ fold16(w_p);
               r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_RUN) begin
               r_hold <= w_hold_end ? '0 : r_hold + 8'd1;
               if (w_hold_end && w_last)
                  r_state <= S_DRAIN;
               else if (w_hold_end)
                  r_vec <= r_vec + 1'b1;
            end else if (r_state == S_DRAIN) begin
               r_state <= S_DONE;
            end
         end
      end
   end
endmodule
